// File: rtl/ram_bist_pkg.sv
// Shared types and the expected-data pattern function for the RAM BIST sequencer.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_ADDR   = 3'd4,
    R_CMP    = 3'd5,
    FIN      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PAT_DOUBLE     = 2'd0,
    PAT_ADDR       = 2'd1,
    PAT_CHECKER    = 2'd2,
    PAT_INV_DOUBLE = 2'd3
  } pattern_e;

  localparam int unsigned PAT_W = 32;

  // Pattern computed at full 32-bit width; callers keep the low WORD_SIZE bits (mod 2**WORD_SIZE).
  function automatic logic [PAT_W-1:0] pattern_word(input logic [PAT_W-1:0] a, input pattern_e sel);
    logic [PAT_W-1:0] w;
    w = '0;
    case (sel)
      PAT_DOUBLE:     w = a << 1;
      PAT_ADDR:       w = a;
      PAT_CHECKER:    w = a[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
      PAT_INV_DOUBLE: w = ~(a << 1);
      default:        w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ram_pattern_gen.sv
// Combinational expected-data generator, shared by the write and compare paths.
module ram_pattern_gen
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 8
) (
  input  logic [ADDR_SIZE-1:0] addr,
  input  pattern_e             sel,
  output logic [WORD_SIZE-1:0] expected_c
);

  logic [PAT_W-1:0] word_c;

  assign word_c     = pattern_word(PAT_W'(addr), sel);
  assign expected_c = word_c[WORD_SIZE-1:0];

endmodule

// File: rtl/ram_bist_ctrl.sv
// Fill-then-verify BIST sequencer driving a level-sensitive RAM; reports pass, error count and first failure.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = 10,
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned MEM_SIZE  = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           pattern_sel,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_din,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [WORD_SIZE-1:0] ram_dout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_SIZE:0]   err_count,
  output logic [ADDR_SIZE-1:0] first_err_addr,
  output logic [WORD_SIZE-1:0] first_err_data
);

  localparam int unsigned ERR_W = ADDR_SIZE + 1;

  state_e                 state_q, state_d;
  pattern_e               sel_q, sel_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [WORD_SIZE-1:0]   din_q, din_d;
  logic                   wr_q, wr_d, cs_q, cs_d, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic [ADDR_SIZE-1:0]   faddr_q, faddr_d;
  logic [WORD_SIZE-1:0]   fdata_q, fdata_d;
  logic [WORD_SIZE-1:0]   expected_c;
  logic                   last_c, mismatch_c;

  // Generator looks at the next address so ram_din is registered alongside ram_addr.
  ram_pattern_gen #(
    .ADDR_SIZE (ADDR_SIZE),
    .WORD_SIZE (WORD_SIZE)
  ) u_pattern_gen (
    .addr       (addr_d),
    .sel        (sel_d),
    .expected_c (expected_c)
  );

  assign last_c     = (addr_q == ADDR_SIZE'(MEM_SIZE - 1));
  // During R_CMP ram_din still carries the expected word for the current address.
  assign mismatch_c = (ram_dout != din_q);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d   = pattern_e'(pattern_sel);
          addr_d  = '0;
          err_d   = '0;
          faddr_d = '0;
          fdata_d = '0;
          pass_d  = 1'b0;
          state_d = W_SETUP;
        end
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD: begin
        if (last_c) begin
          addr_d  = '0;
          state_d = R_ADDR;
        end else begin
          addr_d  = addr_q + ADDR_SIZE'(1);
          state_d = W_SETUP;
        end
      end
      R_ADDR: state_d = R_CMP;
      R_CMP: begin
        if (mismatch_c) begin
          if (err_q == '0) begin
            faddr_d = addr_q;
            fdata_d = ram_dout;
          end
          if (err_q != '1) err_d = err_q + ERR_W'(1);
        end
        if (last_c) begin
          addr_d  = '0;
          pass_d  = (err_d == '0);
          state_d = FIN;
        end else begin
          addr_d  = addr_q + ADDR_SIZE'(1);
          state_d = R_ADDR;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    cs_d   = (state_d == W_SETUP) || (state_d == W_STROBE) || (state_d == R_ADDR) || (state_d == R_CMP);
    wr_d   = (state_d == W_STROBE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    din_d  = (cs_d || (state_d == W_HOLD)) ? expected_c : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= PAT_DOUBLE;
      addr_q  <= '0;
      din_q   <= '0;
      wr_q    <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign ram_addr       = addr_q;
  assign ram_din        = din_q;
  assign ram_wr         = wr_q;
  assign ram_cs         = cs_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = faddr_q;
  assign first_err_data = fdata_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl with a behavioural RAM, fault injection and a bus protocol monitor.
module tb_ram_bist_ctrl;

  localparam int unsigned ADDR_SIZE = 10;
  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned MEM_SIZE  = 1024;
  localparam int unsigned RUN_LEN   = 5 * MEM_SIZE + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [1:0]           pattern_sel = 2'd0;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [WORD_SIZE-1:0] ram_din;
  logic                 ram_wr, ram_cs;
  logic [WORD_SIZE-1:0] ram_dout;
  logic                 busy, done, pass;
  logic [ADDR_SIZE:0]   err_count;
  logic [ADDR_SIZE-1:0] first_err_addr;
  logic [WORD_SIZE-1:0] first_err_data;

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];
  bit                   fault_en = 1'b0;

  int total = 0;
  int bad   = 0;

  ram_bist_ctrl #(.ADDR_SIZE(ADDR_SIZE), .WORD_SIZE(WORD_SIZE), .MEM_SIZE(MEM_SIZE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pattern_sel    (pattern_sel),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_wr         (ram_wr),
    .ram_cs         (ram_cs),
    .ram_dout       (ram_dout),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  // RAM model: write latched mid-strobe, asynchronous read; optional bit0 stuck-at-1 at addresses 4 and 9.
  always @(negedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
  assign ram_dout = mem[ram_addr] |
                    {7'b0, fault_en && (ram_addr == 10'd4 || ram_addr == 10'd9)};

  // Protocol monitor, sampled on the falling edge.
  int                   strobes = 0, compares = 0, prot_viol = 0;
  logic                 p_busy = 1'b0, p_wr = 1'b0, p_cs = 1'b0;
  logic [ADDR_SIZE-1:0] p_addr = '0;
  logic [WORD_SIZE-1:0] p_din = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      p_busy = 1'b0; p_wr = 1'b0; p_cs = 1'b0;
    end else begin
      if (busy && !p_busy) begin strobes = 0; compares = 0; end
      if (ram_wr && !ram_cs) prot_viol++;
      if (ram_wr && (ram_addr != p_addr || ram_din != p_din || !p_cs)) prot_viol++;
      if (p_wr && (ram_addr != p_addr || ram_din != p_din)) prot_viol++;
      if (ram_wr) strobes++;
      if (ram_cs && !ram_wr && p_cs && !p_wr && ram_addr == p_addr) compares++;
      p_busy = busy; p_wr = ram_wr; p_cs = ram_cs; p_addr = ram_addr; p_din = ram_din;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts a run and counts busy cycles; optional extra start pulses and mid-run reset.
  task automatic run(input logic [1:0] sel, input bit inject, input int abort_at,
                     output int cycles, output int done_cnt, output int done_idx);
    cycles = 0; done_cnt = 0; done_idx = 0;
    @(negedge clk);
    pattern_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pattern_sel = ~sel;
    while (busy && cycles < RUN_LEN + 100) begin
      cycles++;
      if (done) begin done_cnt++; done_idx = cycles; end
      start = inject && (cycles == 100 || done);
      if (abort_at != 0 && cycles == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({ram_addr, ram_din, ram_wr, ram_cs, busy, done, pass, err_count,
                   first_err_addr, first_err_data}), 64'd0);
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (cycles >= RUN_LEN + 100) check("run_timeout", 64'(cycles), 64'(RUN_LEN));
  endtask

  typedef struct {
    logic [1:0] sel;
    bit         fault;
    int         peek_addr;
    logic [7:0] peek_val;
    bit         exp_pass;
    int         exp_err;
    int         exp_faddr;
    logic [7:0] exp_fdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int cyc, dcnt, didx;
    vecs[0] = '{2'd0, 1'b0, 300,  8'd88,  1'b1, 0, 0, 8'd0};
    vecs[1] = '{2'd0, 1'b0, 1023, 8'd254, 1'b1, 0, 0, 8'd0};
    vecs[2] = '{2'd2, 1'b0, 6,    8'h55,  1'b1, 0, 0, 8'd0};
    vecs[3] = '{2'd2, 1'b0, 7,    8'hAA,  1'b1, 0, 0, 8'd0};
    vecs[4] = '{2'd3, 1'b0, 1,    8'hFD,  1'b1, 0, 0, 8'd0};
    vecs[5] = '{2'd0, 1'b1, 4,    8'd8,   1'b0, 2, 4, 8'd9};
    vecs[6] = '{2'd1, 1'b0, 513,  8'd1,   1'b1, 0, 0, 8'd0};

    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({ram_addr, ram_din, ram_wr, ram_cs, busy, done, pass, err_count,
               first_err_addr, first_err_data}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      fault_en = vecs[i].fault;
      run(vecs[i].sel, 1'b0, 0, cyc, dcnt, didx);
      check("run_length", 64'(cyc), 64'(RUN_LEN));
      check("done_count", 64'(dcnt), 64'd1);
      check("done_last_cycle", 64'(didx), 64'(RUN_LEN));
      check("pass", 64'(pass), 64'(vecs[i].exp_pass));
      check("err_count", 64'(err_count), 64'(vecs[i].exp_err));
      check("first_err_addr", 64'(first_err_addr), 64'(vecs[i].exp_faddr));
      check("first_err_data", 64'(first_err_data), 64'(vecs[i].exp_fdata));
      check("mem_peek", 64'(mem[vecs[i].peek_addr]), 64'(vecs[i].peek_val));
      check("write_strobes", 64'(strobes), 64'(MEM_SIZE));
      check("compares", 64'(compares), 64'(MEM_SIZE));
    end
    fault_en = 1'b0;

    // Start pulses in the write phase and at FIN must not restart or stretch the run.
    run(2'd3, 1'b1, 0, cyc, dcnt, didx);
    check("ignored_start_len", 64'(cyc), 64'(RUN_LEN));
    check("ignored_start_done", 64'(dcnt), 64'd1);
    @(negedge clk);
    check("no_restart_after_fin", 64'(busy), 64'd0);
    check("ignored_start_pass", 64'(pass), 64'd1);
    check("ignored_start_mem", 64'(mem[1]), 64'hFD);

    // Reset mid-run, then a clean full run.
    run(2'd2, 1'b0, 2000, cyc, dcnt, didx);
    check("abort_no_done", 64'(dcnt), 64'd0);
    repeat (3) @(negedge clk);
    check("abort_held_idle", 64'({busy, done, ram_cs, ram_wr}), 64'd0);
    rst_n = 1'b1;
    run(2'd0, 1'b0, 0, cyc, dcnt, didx);
    check("post_reset_len", 64'(cyc), 64'(RUN_LEN));
    check("post_reset_done", 64'(dcnt), 64'd1);
    check("post_reset_pass", 64'(pass), 64'd1);
    check("post_reset_err", 64'(err_count), 64'd0);
    check("post_reset_mem300", 64'(mem[300]), 64'd88);
    check("post_reset_mem1023", 64'(mem[1023]), 64'd254);

    check("protocol_violations", 64'(prot_viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
